moving_avg_multich: RTL and testbench

MOVING_AVG_MULTICH -- requirements
Module: moving_avg_multich

---
 rtl/mavg_pkg.sv | 19 +
 rtl/mavg_channel.sv | 44 ++++
 rtl/moving_avg_multich.sv | 102 ++++++++++
 tb/tb_moving_avg_multich.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mavg_pkg.sv
// Shared types and width helpers for the multichannel moving-average block.
package mavg_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FILLING = 2'd1,
        ST_FULL    = 2'd2
    } mavg_state_e;

    function automatic int win_depth(input int log2_win);
        return 1 << log2_win;
    endfunction

    // Wide enough to hold WIN * (2**DW - 1) without wrapping.
    function automatic int sum_width(input int dw, input int log2_win);
        return dw + log2_win;
    endfunction

endpackage

// File: rtl/mavg_channel.sv
// One channel: WIN-deep sample shift register plus its exact running sum.
module mavg_channel
    import mavg_pkg::*;
#(
    parameter int DW       = 2,
    parameter int LOG2_WIN = 2,
    localparam int SW      = sum_width(DW, LOG2_WIN),
    localparam int WIN     = win_depth(LOG2_WIN)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          accept,
    input  logic          clear,
    input  logic [DW-1:0] sample,
    output logic [SW-1:0] sum
);

    logic [DW-1:0] window_reg [WIN];
    logic [SW-1:0] sum_reg;

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            window_reg[0] <= '0;
            sum_reg       <= '0;
        end else if (accept) begin
            window_reg[0] <= sample;
            // Intermediate may wrap modulo 2**SW; the final sum always fits.
            sum_reg       <= sum_reg + SW'(sample) - SW'(window_reg[WIN-1]);
        end
    end

    for (genvar gi = 1; gi < WIN; gi++) begin : g_slot
        always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
                window_reg[gi] <= '0;
            end else if (accept) begin
                window_reg[gi] <= window_reg[gi-1];
            end
        end
    end

    assign sum = sum_reg;

endmodule

// File: rtl/moving_avg_multich.sv
// Multichannel moving-window sum/average: fill FSM, fill counter, output mux and gate.
module moving_avg_multich
    import mavg_pkg::*;
#(
    parameter int NCH      = 3,
    parameter int DW       = 2,
    parameter int LOG2_WIN = 2,
    localparam int SW      = sum_width(DW, LOG2_WIN),
    localparam int WIN     = win_depth(LOG2_WIN),
    localparam int FW      = LOG2_WIN + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [NCH*DW-1:0] in_data,
    input  logic              clear,
    input  logic              mode,
    input  logic              out_en,
    output logic              out_valid,
    output logic [NCH*SW-1:0] out_data,
    output logic [FW-1:0]     fill_cnt,
    output logic              full
);

    localparam logic [FW-1:0] WIN_CNT = FW'(WIN);

    mavg_state_e   state_reg, state_next;
    logic [FW-1:0] fill_cnt_reg, fill_cnt_next;
    logic          out_valid_reg, out_valid_next;
    logic          accept;

    // A clear in the same cycle drops the sample.
    assign accept = in_valid && !clear;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            fill_cnt_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            fill_cnt_reg  <= fill_cnt_next;
            out_valid_reg <= out_valid_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        fill_cnt_next  = fill_cnt_reg;
        out_valid_next = 1'b0;
        if (clear) begin
            state_next    = ST_EMPTY;
            fill_cnt_next = '0;
        end else if (accept) begin
            case (state_reg)
                ST_EMPTY: begin
                    fill_cnt_next = FW'(1);
                    state_next    = ST_FILLING;
                end
                ST_FILLING: begin
                    fill_cnt_next = fill_cnt_reg + 1'b1;
                    state_next    = (fill_cnt_next == WIN_CNT) ? ST_FULL : ST_FILLING;
                end
                ST_FULL: begin
                    fill_cnt_next = WIN_CNT;
                    state_next    = ST_FULL;
                end
                default: begin
                    fill_cnt_next = '0;
                    state_next    = ST_EMPTY;
                end
            endcase
            out_valid_next = (state_next == ST_FULL);
        end
    end

    assign out_valid = out_valid_reg;
    assign fill_cnt  = fill_cnt_reg;
    assign full      = (state_reg == ST_FULL);

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [SW-1:0] sum;
        logic [SW-1:0] shown;

        mavg_channel #(
            .DW       (DW),
            .LOG2_WIN (LOG2_WIN)
        ) u_channel (
            .clk    (clk),
            .rst_n  (rst_n),
            .accept (accept),
            .clear  (clear),
            .sample (in_data[gi*DW +: DW]),
            .sum    (sum)
        );

        // mode and out_en act on the output path only, never on stored state.
        assign shown = mode ? (sum >> LOG2_WIN) : sum;
        assign out_data[gi*SW +: SW] = (out_en && state_reg != ST_EMPTY) ? shown : '0;
    end

endmodule

// File: tb/tb_moving_avg_multich.sv
// Directed bench for moving_avg_multich (NCH=3, DW=2, LOG2_WIN=2) with a queue-based output scoreboard.
module tb_moving_avg_multich;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [5:0]  in_data = '0;
    logic        clear = 1'b0;
    logic        mode = 1'b0;
    logic        out_en = 1'b1;
    logic        out_valid;
    logic [11:0] out_data;
    logic [2:0]  fill_cnt;
    logic        full;

    int          checks = 0;
    int          errors = 0;
    int          txn = 0;
    logic [11:0] exp_q [$];

    always #5 clk = ~clk;

    moving_avg_multich #(
        .NCH      (3),
        .DW       (2),
        .LOG2_WIN (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .mode      (mode),
        .out_en    (out_en),
        .out_valid (out_valid),
        .out_data  (out_data),
        .fill_cnt  (fill_cnt),
        .full      (full)
    );

    // Presentation of raw per-channel sums under the bench's current mode/out_en.
    function automatic logic [11:0] fmt(input logic [11:0] s, input logic m, input logic en);
        logic [11:0] r;
        logic [3:0]  v;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            v = s[c*4 +: 4];
            if (m) v = v >> 2;
            if (en) r[c*4 +: 4] = v;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected sum set per out_valid pulse.
    always @(negedge clk) begin
        logic [11:0] e;
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got out_data=%0h with empty queue", out_data);
            end else begin
                e = fmt(exp_q.pop_front(), mode, out_en);
                txn++;
                $display("txn %0d out_data=%h expected=%h", txn, out_data, e);
                chk("out_data", out_data, e);
                chk("full_at_valid", 12'(full), 12'd1);
            end
        end
    end

    // One cycle of stimulus; expected sums are hand-computed by the caller.
    task automatic step(input logic v, input logic [5:0] d, input logic clr,
                        input logic expv, input logic [11:0] esum,
                        input logic [2:0] efill, input string name);
        #1;
        in_valid = v;
        in_data  = d;
        clear    = clr;
        if (expv) exp_q.push_back(esum);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
        @(negedge clk);
        chk({name, "_valid"}, 12'(out_valid), 12'(expv));
        chk({name, "_fill"}, 12'(fill_cnt), 12'(efill));
    endtask

    localparam logic [5:0] D_312 = {2'd2, 2'd1, 2'd3};
    localparam logic [5:0] D_123 = {2'd3, 2'd2, 2'd1};
    localparam logic [5:0] D_333 = {2'd3, 2'd3, 2'd3};

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 12'(out_valid), 12'd0);
        chk("rst_data", out_data, 12'h000);
        chk("rst_full", 12'(full), 12'd0);
        chk("rst_fill", 12'(fill_cnt), 12'd0);
        #1 rst_n = 1'b1;

        // Fill: ch0=3 ch1=1 ch2=2
        step(1, D_312, 0, 0, 12'h000, 3'd1, "fill1");
        chk("fill1_data", out_data, 12'h213);
        step(1, D_312, 0, 0, 12'h000, 3'd2, "fill2");
        step(1, D_312, 0, 0, 12'h000, 3'd3, "fill3");
        chk("fill3_full", 12'(full), 12'd0);
        step(1, D_312, 0, 1, 12'h84C, 3'd4, "fill4");
        chk("fill4_full", 12'(full), 12'd1);

        // Slide zeros in; first one viewed as an average
        #1 mode = 1'b1;
        step(1, 6'd0, 0, 1, 12'h639, 3'd4, "slide1");
        chk("mode_avg", out_data, 12'h102);
        #1 mode = 1'b0;
        #1 chk("mode_raw", out_data, 12'h639);
        step(1, 6'd0, 0, 1, 12'h426, 3'd4, "slide2");
        step(1, 6'd0, 0, 1, 12'h213, 3'd4, "slide3");
        step(1, 6'd0, 0, 1, 12'h000, 3'd4, "slide4");

        // Gaps: idle cycles hold everything
        step(1, D_123, 0, 1, 12'h321, 3'd4, "gap_acc1");
        step(0, D_333, 0, 0, 12'h000, 3'd4, "gap_idle1");
        chk("gap_hold1", out_data, 12'h321);
        step(1, D_123, 0, 1, 12'h642, 3'd4, "gap_acc2");
        step(0, D_333, 0, 0, 12'h000, 3'd4, "gap_idle2");
        chk("gap_hold2", out_data, 12'h642);

        // Gate: outputs zeroed, state still advances
        #1 out_en = 1'b0;
        step(1, D_123, 0, 1, 12'h963, 3'd4, "gate1");
        step(1, D_123, 0, 1, 12'hC84, 3'd4, "gate2");
        #1 out_en = 1'b1;
        #1 chk("gate_release", out_data, 12'hC84);

        // Clear collides with a sample
        step(1, D_333, 1, 0, 12'h000, 3'd0, "clr");
        chk("clr_full", 12'(full), 12'd0);
        chk("clr_data", out_data, 12'h000);

        // Saturation then mid-stream reset
        step(1, D_333, 0, 0, 12'h000, 3'd1, "sat1");
        chk("sat1_data", out_data, 12'h333);
        step(1, D_333, 0, 0, 12'h000, 3'd2, "sat2");
        step(1, D_333, 0, 0, 12'h000, 3'd3, "sat3");
        step(1, D_333, 0, 1, 12'hCCC, 3'd4, "sat4");
        step(1, D_333, 0, 1, 12'hCCC, 3'd4, "sat5");
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_valid", 12'(out_valid), 12'd0);
        chk("mrst_data", out_data, 12'h000);
        chk("mrst_full", 12'(full), 12'd0);
        chk("mrst_fill", 12'(fill_cnt), 12'd0);
        #1 rst_n = 1'b1;
        step(1, D_333, 0, 0, 12'h000, 3'd1, "post_rst");
        chk("post_rst_data", out_data, 12'h333);

        repeat (2) @(negedge clk);
        chk("queue_drained", 12'(exp_q.size()), 12'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
